result_drain_ctrl: RTL and testbench

Synthesizable sequencer that drains an N×N result matrix from the result RAM in row-major order and streams each 32-bit element, tagged with its row/column indices, to a downstream sink over a valid/ready handshake. It sits between the multiplier's result memory and the output stage. It is the hardware replacement for the behavioural writer loop. A 2-entry output buffer hides the RAM's 1-cycle read latency and sustains one element per cycle under no backpressure.

---
 rtl/result_drain_ctrl.sv | 88 ++++++++
 tb/tb_result_drain_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/result_drain_ctrl.sv
// result_drain_ctrl: drains an NxN result RAM row-major into a valid/ready stream
// through a 2-entry buffer that hides the RAM's one-cycle read latency.
module result_drain_ctrl #(
    parameter int N  = 8,
    parameter int DW = 32,
    parameter int IW = $clog2(N),
    parameter int AW = $clog2(N*N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [IW-1:0] out_i,
    output logic [IW-1:0] out_j
);
    localparam int NN = N*N;
    localparam int EW = DW + 2*IW;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [AW:0] issued, popped;
    logic [IW-1:0] i, j, fi, fj;
    logic inflight, pop, cap;
    logic [1:0] occ, pos;
    logic [2:0] cred;
    logic [EW-1:0] q0, q1, entry;
    assign out_valid = occ != 2'd0;
    assign {out_data, out_i, out_j} = q0;
    assign pop = out_valid && out_ready;
    assign cap = inflight;
    assign pos = occ - {1'b0, pop};
    assign entry = {rd_data, fi, fj};
    // Credit counts buffered plus in-flight elements, net of this cycle's pop.
    assign cred = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign rd_en = state == RUN && issued != (AW+1)'(NN) && cred < 3'd2;
    assign rd_addr = AW'(int'(i) * N + int'(j));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            issued <= '0;
            popped <= '0;
            i <= '0;
            j <= '0;
            fi <= '0;
            fj <= '0;
            inflight <= 1'b0;
            occ <= '0;
            q0 <= '0;
            q1 <= '0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                {fi, fj} <= {i, j};
                issued <= issued + 1'b1;
                j <= j == IW'(N-1) ? '0 : j + 1'b1;
                i <= j == IW'(N-1) ? i + 1'b1 : i;
            end
            if (pop) q0 <= q1;
            if (cap && pos == 2'd0) q0 <= entry;
            if (cap && pos == 2'd1) q1 <= entry;
            occ <= occ + {1'b0, cap} - {1'b0, pop};
            if (pop) popped <= popped + 1'b1;
            if (state == RUN) begin
                if (pop && popped == (AW+1)'(NN-1)) begin
                    state <= DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start) begin
                state <= RUN;
                busy <= 1'b1;
                done <= 1'b0;
                issued <= '0;
                popped <= '0;
                i <= '0;
                j <= '0;
            end
        end
    end
endmodule

// File: tb/tb_result_drain_ctrl.sv
// tb_result_drain_ctrl: randomized and directed drains of N=4 and N=8 instances
// checked against an element-sequence reference model.
module tb_result_drain_ctrl;
    logic clk = 0, rst = 1, start = 0, out_ready = 0, sel = 0;
    always #5 clk = ~clk;
    logic bz4, dn4, re4, v4, bz8, dn8, re8, v8;
    logic [3:0] ra4;
    logic [5:0] ra8;
    logic [1:0] i4, j4;
    logic [2:0] i8, j8;
    logic [31:0] rd4, rd8, d4, d8;
    logic v, re, bz, dn;
    logic [31:0] dat, oi, oj, ra;
    int checks = 0, errors = 0;

    result_drain_ctrl #(.N(4)) dut4 (.clk(clk), .rst(rst), .start(start & ~sel), .busy(bz4), .done(dn4),
        .rd_en(re4), .rd_addr(ra4), .rd_data(rd4), .out_valid(v4), .out_ready(out_ready),
        .out_data(d4), .out_i(i4), .out_j(j4));
    result_drain_ctrl #(.N(8)) dut8 (.clk(clk), .rst(rst), .start(start & sel), .busy(bz8), .done(dn8),
        .rd_en(re8), .rd_addr(ra8), .rd_data(rd8), .out_valid(v8), .out_ready(out_ready),
        .out_data(d8), .out_i(i8), .out_j(j8));

    always @(posedge clk) begin
        rd4 <= re4 ? 32'h100 + 32'(ra4) : $urandom;
        rd8 <= re8 ? ~32'(ra8) : $urandom;
    end

    always_comb begin
        v = sel ? v8 : v4;
        re = sel ? re8 : re4;
        bz = sel ? bz8 : bz4;
        dn = sel ? dn8 : dn4;
        dat = sel ? d8 : d4;
        oi = sel ? 32'(i8) : 32'(i4);
        oj = sel ? 32'(j8) : 32'(j4);
        ra = sel ? 32'(ra8) : 32'(ra4);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input int k);
        return sel ? ~32'(k) : 32'h100 + 32'(k);
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, v, 0);
        chk({tag, "_data"}, dat, 0);
        chk({tag, "_i"}, oi, 0);
        chk({tag, "_j"}, oj, 0);
        chk({tag, "_rd_en"}, re, 0);
        chk({tag, "_rd_addr"}, ra, 0);
        chk({tag, "_busy"}, bz, 0);
        chk({tag, "_done"}, dn, 0);
    endtask

    // mode: 0 ready=1, 1 stall cycles 3..8, 2 toggling ready, 3 random ready, 4 start pulse in RUN
    task automatic drain(input int mode, input int abort_at);
        int n = sel ? 8 : 4;
        int nn = n * n;
        int k = 0, issued = 0, last_pop = 0;
        logic pv = 0, pr = 0;
        logic [31:0] pd = 0, pi = 0, pj = 0;
        @(negedge clk);
        start = 1;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            start = mode == 4 && c == 6;
            out_ready = mode == 1 ? !(c >= 3 && c <= 8) :
                        mode == 2 ? c % 2 == 1 :
                        mode == 3 ? 1'($urandom % 2) : 1'b1;
            #1;
            chk("done", dn, k == nn);
            chk("busy", bz, k != nn);
            if (mode == 0 || mode == 4) begin
                chk("valid_timing", v, c >= 3 && c <= nn + 2);
                chk("rd_en_timing", re, c <= nn);
            end
            if (pv && !pr) begin
                chk("hold_valid", v, 1);
                chk("hold_data", dat, pd);
                chk("hold_i", oi, pi);
                chk("hold_j", oj, pj);
            end
            if (re) begin
                chk("rd_addr", ra, issued);
                issued++;
            end
            if (mode == 1 && c == 8) chk("pre_pop_reads", issued, 2);
            if (v && out_ready) begin
                chk("data", dat, exp_data(k));
                chk("i", oi, k / n);
                chk("j", oj, k % n);
                k++;
                last_pop = c;
            end
            chk("outstanding", issued - k <= 2, 1);
            pv = v;
            pr = out_ready;
            pd = dat;
            pi = oi;
            pj = oj;
            if (abort_at > 0 && k == abort_at) begin
                #2 rst = 1;
                #1 chk_zero("abort");
                @(negedge clk);
                rst = 0;
                out_ready = 0;
                return;
            end
            if (k == nn && c == last_pop + 2) break;
        end
        chk("beats", k, nn);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("done_held", dn, 1);
            chk("idle_rd_en", re, 0);
            chk("idle_valid", v, 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1 chk_zero("reset");
        rst = 0;
        drain(0, 0);
        drain(1, 0);
        drain(2, 0);
        drain(4, 0);
        drain(0, 7);
        drain(0, 0);
        repeat (3) drain(3, 0);
        sel = 1;
        drain(0, 0);
        drain(3, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
